// File: rtl/skolem_sweep_checker.sv
// Sweep checker for a combinational Skolem function block.
// Walks every universal vector x, waits for the block to settle, samples its
// existential response y and looks up whether (x, y) is allowed by the
// relation truth table. Reports pass/fail, a saturating failure count and the
// first counterexample seen.
module skolem_sweep_checker #(
  parameter int unsigned N_X          = 5,
  parameter int unsigned N_Y          = 2,
  parameter int unsigned SETTLE       = 1,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [2**(N_X+N_Y)-1:0]    spec,
  output logic [N_X-1:0]             x_out,
  input  logic [N_Y-1:0]             y_in,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_X:0]               fail_count,
  output logic                       cex_valid,
  output logic [N_X-1:0]             cex_x,
  output logic [N_Y-1:0]             cex_y
);

  localparam int unsigned NIdx = N_X + N_Y;
  localparam int unsigned CntW = $clog2(SETTLE + 1);
  localparam logic [N_X-1:0] XLast   = '1;
  localparam logic [N_X:0]   FailMax = (N_X + 1)'(1) << N_X;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  state_e          state;
  logic [CntW-1:0] settle_cnt;
  logic [NIdx-1:0] idx;
  logic            ok;
  logic [N_X:0]    fail_nxt;

  // Relation lookup for the current (x, y) pair and the saturated failure count.
  always_comb begin
    idx      = {x_out, y_in};
    ok       = spec[idx];
    fail_nxt = fail_count;
    if (!ok && (fail_count != FailMax)) begin
      fail_nxt = fail_count + 1'b1;
    end
  end

  // Sweep FSM; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      settle_cnt <= '0;
      x_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      cex_valid  <= 1'b0;
      cex_x      <= '0;
      cex_y      <= '0;
    end else if (abort) begin
      // Partial fail_count / cex_* are deliberately kept for inspection.
      state <= StIdle;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state      <= StDrive;
            x_out      <= '0;
            settle_cnt <= '0;
            fail_count <= '0;
            cex_valid  <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        StDrive: begin
          if (settle_cnt == CntLast) begin
            settle_cnt <= '0;
            state      <= StSample;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        StSample: begin
          fail_count <= fail_nxt;
          if (!ok && !cex_valid) begin
            cex_valid <= 1'b1;
            cex_x     <= x_out;
            cex_y     <= y_in;
          end
          // The last vector ends the sweep; x_out never wraps.
          if ((!ok && STOP_ON_FAIL) || (x_out == XLast)) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_nxt == '0);
          end else begin
            x_out <= x_out + 1'b1;
            state <= StDrive;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Bench for skolem_sweep_checker: three instances (stop-on-fail, full sweep,
// long settle) driven from per-instance response tables and checked against
// a vector-level reference model.
module tb_skolem_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_a [3];
  logic         abort_a [3];
  logic [127:0] spec_a  [3];
  logic [1:0]   resp    [3][32];

  wire  [4:0]   x_a     [3];
  wire  [1:0]   y_a     [3];
  wire          busy_a  [3];
  wire          done_a  [3];
  wire          pass_a  [3];
  wire  [5:0]   fc_a    [3];
  wire          cv_a    [3];
  wire  [4:0]   cx_a    [3];
  wire  [1:0]   cy_a    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    skolem_sweep_checker #(
      .N_X          (5),
      .N_Y          (2),
      .SETTLE       ((g == 2) ? 3 : 1),
      .STOP_ON_FAIL ((g == 1) ? 1'b0 : 1'b1)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_a[g]),
      .abort      (abort_a[g]),
      .spec       (spec_a[g]),
      .x_out      (x_a[g]),
      .y_in       (y_a[g]),
      .busy       (busy_a[g]),
      .done       (done_a[g]),
      .pass       (pass_a[g]),
      .fail_count (fc_a[g]),
      .cex_valid  (cv_a[g]),
      .cex_x      (cx_a[g]),
      .cex_y      (cy_a[g])
    );
    // Behavioural stand-in for the Skolem block.
    assign y_a[g] = resp[g][x_a[g]];
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int settle_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  // Vector-level expectation: which vectors fail, where the sweep stops.
  function automatic void model(input int k, output int fails, output bit cv,
                                output int cx, output int cy, output int cycles);
    int last;
    fails = 0; cv = 1'b0; cx = 0; cy = 0; last = 31;
    for (int x = 0; x < 32; x++) begin
      int y;
      y = int'(resp[k][x]);
      if (!spec_a[k][x * 4 + y]) begin
        fails++;
        if (!cv) begin
          cv = 1'b1; cx = x; cy = y;
        end
        if (k != 1) begin
          last = x;
          break;
        end
      end
    end
    cycles = (last + 1) * (settle_of(k) + 1);
  endfunction

  task automatic kick(input int k);
    @(negedge clk) start_a[k] = 1'b1;
    @(posedge clk);
    #1 start_a[k] = 1'b0;
  endtask

  task automatic run_sweep(input int k, input bit poke);
    int ef, ecx, ecy, ecyc, c, s;
    bit ecv;
    model(k, ef, ecv, ecx, ecy, ecyc);
    s = settle_of(k);
    kick(k);
    check("start_clr_fc", fc_a[k], 0);
    check("start_clr_cv", cv_a[k], 0);
    check("start_busy", busy_a[k], 1);
    c = 0;
    while (c < 300 && !done_a[k]) begin
      check("x_seq", x_a[k], c / (s + 1));
      if (poke && c == 3) start_a[k] = 1'b1;
      if (poke && c == 4) start_a[k] = 1'b0;
      @(posedge clk);
      #1 c++;
    end
    check("sweep_cycles", c, ecyc);
    check("x_last", x_a[k], ecyc / (s + 1) - 1);
    check("pass", pass_a[k], (ef == 0) ? 1 : 0);
    check("fail_count", fc_a[k], ef);
    check("cex_valid", cv_a[k], ecv);
    if (ecv) begin
      check("cex_x", cx_a[k], ecx);
      check("cex_y", cy_a[k], ecy);
    end
    check("busy_at_done", busy_a[k], 0);
    @(posedge clk);
    #1 check("done_one_cycle", done_a[k], 0);
    check("pass_hold", pass_a[k], (ef == 0) ? 1 : 0);
  endtask

  task automatic check_zero(input int k);
    check("rz_x", x_a[k], 0);
    check("rz_busy", busy_a[k], 0);
    check("rz_done", done_a[k], 0);
    check("rz_pass", pass_a[k], 0);
    check("rz_fc", fc_a[k], 0);
    check("rz_cv", cv_a[k], 0);
    check("rz_cx", cx_a[k], 0);
    check("rz_cy", cy_a[k], 0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0;
      abort_a[k] = 1'b0;
      spec_a[k]  = '1;
      for (int x = 0; x < 32; x++) resp[k][x] = 2'b00;
    end
    #23 rst = 1'b0;
    for (int k = 0; k < 3; k++) check_zero(k);

    // All-allowed relation: full sweep, pass.
    run_sweep(0, 1'b0);

    // Relation y == {x1^x0, x4}; correct block, then a broken vector 6.
    spec_a[0] = '0;
    for (int x = 0; x < 32; x++) begin
      logic [4:0] xv;
      xv = 5'(x);
      resp[0][x] = {xv[1] ^ xv[0], xv[4]};
      spec_a[0][x * 4 + int'(resp[0][x])] = 1'b1;
    end
    run_sweep(0, 1'b0);
    resp[0][6] = 2'b00;
    run_sweep(0, 1'b0);
    check("t2_cex_x", cx_a[0], 6);

    // Nothing allowed, no stop: every vector fails, no overflow.
    spec_a[1] = '0;
    run_sweep(1, 1'b0);
    check("t3_fc32", fc_a[1], 32);

    // Abort ten cycles in: five vectors sampled so far, all failing.
    kick(1);
    c = 0;
    while (c < 10) begin
      @(posedge clk);
      #1 c++;
    end
    abort_a[1] = 1'b1;
    @(posedge clk);
    #1 abort_a[1] = 1'b0;
    check("abort_busy", busy_a[1], 0);
    check("abort_pass", pass_a[1], 0);
    check("abort_fc_partial", fc_a[1], 5);
    check("abort_cv_partial", cv_a[1], 1);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", done_a[1], 0);
      @(posedge clk);
      #1;
    end
    run_sweep(1, 1'b0);

    // Reset mid-sweep takes effect without a clock edge.
    for (int x = 0; x < 32; x++) resp[0][x] = 2'b00;
    spec_a[0] = '1;
    kick(0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero(0);
    @(negedge clk) rst = 1'b0;
    // Start pulses during busy must not disturb the sweep.
    run_sweep(0, 1'b1);

    // start and abort together in idle: abort wins.
    @(negedge clk);
    start_a[0] = 1'b1;
    abort_a[0] = 1'b1;
    @(posedge clk);
    #1 start_a[0] = 1'b0;
    abort_a[0] = 1'b0;
    check("sa_busy", busy_a[0], 0);
    @(posedge clk);
    #1 check("sa_busy2", busy_a[0], 0);
    check("sa_done", done_a[0], 0);

    // Long settle.
    run_sweep(2, 1'b0);

    // Randomized relations and responses on every instance.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 128; i++) begin
          spec_a[k][i] = (k == 1) ? ($urandom_range(0, 1) != 0)
                                  : ($urandom_range(0, 39) != 0);
        end
        for (int x = 0; x < 32; x++) resp[k][x] = 2'($urandom_range(0, 3));
        run_sweep(k, 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
